ahb_split_arbiter: RTL

- AHB bus arbiter for NUM_MASTERS masters with full SPLIT support.
- Grants the bus round-robin among requesting masters and holds the grant for fixed-length bursts and locked sequences.
- Masks any master that receives a SPLIT response until a slave re-enables it through HSPLIT.
- Drives HGRANT, HMASTER and HMASTLOCK to the address/control mux and to the split-capable slaves.

---
 rtl/ahb_pkg.sv | 46 ++++
 rtl/ahb_rr_picker.sv | 29 ++
 rtl/ahb_split_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and arbiter state for the bus arbiter and its helpers.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        OKAY  = 2'd0,
        ERROR = 2'd1,
        RETRY = 2'd2,
        SPLIT = 2'd3
    } hresp_e;

    typedef enum logic [1:0] {
        PARK  = 2'd0,
        OWN   = 2'd1,
        BURST = 2'd2,
        LOCK  = 2'd3
    } arb_state_e;

    // SEQ beats that follow the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
    function automatic logic [3:0] burst_beats(input hburst_e b);
        case (b)
            WRAP4, INCR4:   return 4'd3;
            WRAP8, INCR8:   return 4'd7;
            WRAP16, INCR16: return 4'd15;
            default:        return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin priority encoder: first request after ptr, wrapping.
module ahb_rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         valid
);

    logic [W-1:0] idx_s;
    logic         hit_s;

    // Scan ptr+1 .. ptr (mod N); the first hit wins and later hits are ignored.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx_s  = '0;
        hit_s  = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx_s  = W'((int'(ptr) + i) % N);
            hit_s  = !valid && req[idx_s];
            winner = hit_s ? idx_s : winner;
            valid  = valid | hit_s;
        end
    end

endmodule

// File: rtl/ahb_split_arbiter.sv
// AHB arbiter: round-robin grant with burst/lock hold and SPLIT masking.
// Ownership (HMASTER/HMASTLOCK) trails the registered grant by one HREADY edge.
module ahb_split_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    input  logic [NUM_MASTERS-1:0] HSPLIT,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK,
    output logic [NUM_MASTERS-1:0] split_mask
);

    localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1'b1) << DEFAULT_MASTER;

    arb_state_e             state_r, state_nxt_s;
    logic [NUM_MASTERS-1:0] grant_r, grant_nxt_s;
    logic [MW-1:0]          owner_r, owner_nxt_s;
    logic [MW-1:0]          rr_ptr_r, rr_ptr_nxt_s;
    logic [MW-1:0]          hmaster_r, data_master_r;
    logic                   hmastlock_r;
    logic [NUM_MASTERS-1:0] split_mask_r, mask_nxt_s, set_vec_s;
    logic [3:0]             beat_cnt_r, beat_nxt_s;
    logic                   lock_tail_r, lock_tail_nxt_s;
    logic                   rearb_s;

    htrans_e                trans_s;
    hresp_e                 resp_s;
    logic [NUM_MASTERS-1:0] elig_s;
    logic [MW-1:0]          win_s, arb_idx_s;
    logic                   win_vld_s;
    logic                   resp_first_s, split_first_s, burst_start_s, owner_lock_s, any_elig_s;

    assign trans_s       = htrans_e'(HTRANS);
    assign resp_s        = hresp_e'(HRESP);
    assign resp_first_s  = !HREADY && (resp_s != OKAY);
    assign split_first_s = !HREADY && (resp_s == SPLIT);
    assign owner_lock_s  = HLOCK[owner_r];
    // A burst only freezes the grant if the master starting it still holds the grant.
    assign burst_start_s = (trans_s == NONSEQ) && (burst_beats(hburst_e'(HBURST)) != 4'd0)
                           && (hmaster_r == owner_r);

    // Split-mask set vector for the master owning the data phase.
    always_comb begin
        set_vec_s                = '0;
        set_vec_s[data_master_r] = split_first_s;
    end

    // Set beats clear when both hit the same master; arbitration sees the updated mask.
    assign mask_nxt_s = (split_mask_r & ~HSPLIT) | set_vec_s;
    assign elig_s     = HBUSREQ & ~mask_nxt_s;
    assign any_elig_s = |elig_s;

    ahb_rr_picker #(
        .N (NUM_MASTERS),
        .W (MW)
    ) u_picker (
        .req    (elig_s),
        .ptr    (rr_ptr_r),
        .winner (win_s),
        .valid  (win_vld_s)
    );

    assign arb_idx_s = win_vld_s ? win_s : DEF_IDX;

    // FSM state register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r <= PARK;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; also decides when the grant may be re-arbitrated.
    always_comb begin
        state_nxt_s     = state_r;
        rearb_s         = 1'b0;
        beat_nxt_s      = beat_cnt_r;
        lock_tail_nxt_s = lock_tail_r;
        if (resp_first_s) begin
            state_nxt_s     = OWN;
            rearb_s         = split_first_s;
            beat_nxt_s      = 4'd0;
            lock_tail_nxt_s = 1'b0;
        end else if (HREADY) begin
            case (state_r)
                PARK: begin
                    rearb_s     = 1'b1;
                    state_nxt_s = any_elig_s ? OWN : PARK;
                end
                OWN: begin
                    if (owner_lock_s) begin
                        state_nxt_s     = LOCK;
                        lock_tail_nxt_s = 1'b0;
                    end else if (burst_start_s) begin
                        state_nxt_s = BURST;
                        beat_nxt_s  = burst_beats(hburst_e'(HBURST));
                    end else begin
                        rearb_s     = 1'b1;
                        state_nxt_s = any_elig_s ? OWN : PARK;
                    end
                end
                BURST: begin
                    if (trans_s == SEQ) begin
                        if (beat_cnt_r <= 4'd1) begin
                            rearb_s     = 1'b1;
                            beat_nxt_s  = 4'd0;
                            state_nxt_s = any_elig_s ? OWN : PARK;
                        end else begin
                            beat_nxt_s = beat_cnt_r - 4'd1;
                        end
                    end else if (trans_s == BUSY) begin
                        beat_nxt_s = beat_cnt_r;
                    end else begin
                        beat_nxt_s  = 4'd0;
                        state_nxt_s = OWN;
                    end
                end
                LOCK: begin
                    if (owner_lock_s) begin
                        lock_tail_nxt_s = 1'b0;
                    end else if (!lock_tail_r) begin
                        lock_tail_nxt_s = 1'b1;
                    end else begin
                        lock_tail_nxt_s = 1'b0;
                        rearb_s         = 1'b1;
                        state_nxt_s     = any_elig_s ? OWN : PARK;
                    end
                end
                default: begin
                    state_nxt_s = PARK;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Grant / round-robin pointer outputs of the FSM.
    always_comb begin
        grant_nxt_s  = grant_r;
        owner_nxt_s  = owner_r;
        rr_ptr_nxt_s = rr_ptr_r;
        if (rearb_s) begin
            owner_nxt_s            = arb_idx_s;
            grant_nxt_s            = '0;
            grant_nxt_s[arb_idx_s] = 1'b1;
            rr_ptr_nxt_s           = (arb_idx_s != owner_r) ? arb_idx_s : rr_ptr_r;
        end else begin
            grant_nxt_s = grant_r;
        end
    end

    // Datapath registers: grant, ownership pipeline, masks and counters.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            grant_r       <= DEF_GRANT;
            owner_r       <= DEF_IDX;
            rr_ptr_r      <= DEF_IDX;
            hmaster_r     <= DEF_IDX;
            data_master_r <= DEF_IDX;
            hmastlock_r   <= 1'b0;
            split_mask_r  <= '0;
            beat_cnt_r    <= 4'd0;
            lock_tail_r   <= 1'b0;
        end else begin
            grant_r      <= grant_nxt_s;
            owner_r      <= owner_nxt_s;
            rr_ptr_r     <= rr_ptr_nxt_s;
            split_mask_r <= mask_nxt_s;
            beat_cnt_r   <= beat_nxt_s;
            lock_tail_r  <= lock_tail_nxt_s;
            if (HREADY) begin
                hmaster_r     <= owner_r;
                hmastlock_r   <= owner_lock_s;
                data_master_r <= hmaster_r;
            end else begin
                hmaster_r     <= hmaster_r;
                hmastlock_r   <= hmastlock_r;
                data_master_r <= data_master_r;
            end
        end
    end

    assign HGRANT     = grant_r;
    assign HMASTER    = hmaster_r;
    assign HMASTLOCK  = hmastlock_r;
    assign split_mask = split_mask_r;

endmodule
